ram_arbiter: RTL and testbench

//  Shares one single-port synchronous-write RAM (bidirectional data bus, active-low write enable)

---
 rtl/ram_arb_pkg.sv | 12 +
 rtl/ram_arb_pick.sv | 32 +++
 rtl/ram_arbiter.sv | 107 ++++++++++
 tb/tb_ram_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and requester ids for the RAM arbiter
package ram_arb_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/ram_arb_pick.sv
// rtl/ram_arb_pick.sv - winner select between requesters A and B
// ROUND_ROBIN_EN selects alternating tie-break; otherwise A has fixed priority.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = a_req | b_req;

`ifdef ROUND_ROBIN_EN
  // A tie goes to whoever was not served last, so the two alternate.
  always_comb begin
    grant_id = REQ_A;
    if (a_req && b_req) begin
      grant_id = (last_grant == REQ_A) ? REQ_B : REQ_A;
    end else if (b_req) begin
      grant_id = REQ_B;
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  assign grant_id = (b_req && !a_req) ? REQ_B : REQ_A;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester arbiter for a single-port tri-state RAM
// Tie-break policy is chosen by ROUND_ROBIN_EN inside ram_arb_pick.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  a_wr,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic                  b_wr,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  state_t                state;
  logic                  last_grant;
  logic                  lat_id;
  logic                  lat_wr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic                  grant_valid;
  logic                  grant_id;
  logic                  accept;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  ram_arb_pick u_pick (
    .a_req       (a_req),
    .b_req       (b_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign accept    = (state == ST_IDLE) && grant_valid;
  assign a_ack     = accept && (grant_id == REQ_A);
  assign b_ack     = accept && (grant_id == REQ_B);
  assign sel_wr    = (grant_id == REQ_B) ? b_wr    : a_wr;
  assign sel_addr  = (grant_id == REQ_B) ? b_addr  : a_addr;
  assign sel_wdata = (grant_id == REQ_B) ? b_wdata : a_wdata;

  // we_q alone gates both the write strobe and our bus driver, so they can never disagree.
  assign busy     = (state == ST_ACCESS);
  assign ram_we   = we_q;
  assign ram_addr = addr_q;
  assign ram_data = we_q ? {DATA_WIDTH{1'bz}} : lat_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      last_grant <= REQ_B;
      lat_id     <= REQ_A;
      lat_wr     <= 1'b0;
      lat_wdata  <= '0;
      addr_q     <= '0;
      we_q       <= 1'b1;
      rdata      <= '0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state      <= ST_ACCESS;
            last_grant <= grant_id;
            lat_id     <= grant_id;
            lat_wr     <= sel_wr;
            lat_wdata  <= sel_wdata;
            addr_q     <= sel_addr;
            we_q       <= ~sel_wr;
          end
        end
        ST_ACCESS: begin
          state  <= ST_IDLE;
          addr_q <= '0;
          we_q   <= 1'b1;
          if (!lat_wr) begin
            rdata    <= ram_data;
            a_rvalid <= (lat_id == REQ_A);
            b_rvalid <= (lat_id == REQ_B);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter with a behavioural RAM and scoreboard
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mem_clear = 1'b1;
  logic       a_req = 1'b0, a_wr = 1'b0, b_req = 1'b0, b_wr = 1'b0;
  logic [7:0] a_addr = '0, b_addr = '0;
  logic [3:0] a_wdata = '0, b_wdata = '0;
  logic       a_ack, a_rvalid, b_ack, b_rvalid, busy, ram_we;
  logic [3:0] rdata;
  logic [7:0] ram_addr;
  wire  [3:0] ram_data;

  int checks = 0;
  int failures = 0;

  logic [3:0] mem [256];
  logic [3:0] sb [256];
  logic [3:0] m_rdata = 4'h0;
  logic       mlast = 1'b1;

  typedef struct {
    logic       id;
    logic       wr;
    logic [7:0] addr;
    logic [3:0] wd;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl [9];

  ram_arbiter #(.DATA_WIDTH(4), .ADDR_WIDTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .a_req    (a_req),
    .a_wr     (a_wr),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_ack    (a_ack),
    .a_rvalid (a_rvalid),
    .b_req    (b_req),
    .b_wr     (b_wr),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_ack    (b_ack),
    .b_rvalid (b_rvalid),
    .rdata    (rdata),
    .busy     (busy),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_data (ram_data)
  );

  always #5 clk = ~clk;

  // RAM: drives the bus whenever we is high, writes on the edge while we is low.
  assign ram_data = ram_we ? mem[ram_addr] : 4'bzzzz;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 4'h0;
    end else if (!ram_we) begin
      mem[ram_addr] <= ram_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Bus monitor: with we high only the RAM may drive, and we may only drop during an access.
  always @(negedge clk) begin
    if (!mem_clear) begin
      if (ram_we) chk("bus_ram_only", 32'(ram_data), 32'(mem[ram_addr]));
      else        chk("drive_only_in_access", 32'(busy), 32'd1);
    end
  end

  function automatic logic ref_winner(input logic a, input logic b, input logic last);
    if (a && b) begin
`ifdef ROUND_ROBIN_EN
      return ~last;
`else
      return 1'b0;
`endif
    end
    return b && !a;
  endfunction

  task automatic drive(input logic id, input logic req, input logic wr,
                       input logic [7:0] ad, input logic [3:0] wd);
    if (id == 1'b0) begin
      a_req = req; a_wr = wr; a_addr = ad; a_wdata = wd;
    end else begin
      b_req = req; b_wr = wr; b_addr = ad; b_wdata = wd;
    end
  endtask

  task automatic expect_cycle(input logic ack_v, input logic ack_id, input logic rv_v,
                              input logic rv_id, input logic acc, input logic wr,
                              input logic [7:0] ad, input logic [3:0] wd);
    chk("a_ack", 32'(a_ack), 32'(ack_v && ack_id == 1'b0));
    chk("b_ack", 32'(b_ack), 32'(ack_v && ack_id == 1'b1));
    chk("a_rvalid", 32'(a_rvalid), 32'(rv_v && rv_id == 1'b0));
    chk("b_rvalid", 32'(b_rvalid), 32'(rv_v && rv_id == 1'b1));
    chk("busy", 32'(busy), 32'(acc));
    chk("ram_we", 32'(ram_we), acc ? 32'(!wr) : 32'd1);
    chk("ram_addr", 32'(ram_addr), acc ? 32'(ad) : 32'd0);
    if (acc && wr) chk("ram_data_wr", 32'(ram_data), 32'(wd));
    chk("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  task automatic txn(input logic id, input logic wr, input logic [7:0] ad,
                     input logic [3:0] wd, input logic [3:0] exp);
    logic w;
    @(posedge clk); #1;
    drive(id, 1'b1, wr, ad, wd);
    @(negedge clk);
    w = ref_winner(id == 1'b0, id == 1'b1, mlast);
    expect_cycle(1'b1, w, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 4'h0);
    mlast = w;
    @(posedge clk); #1;
    drive(id, 1'b0, 1'b0, 8'h0, 4'h0);
    @(negedge clk);
    expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, wr, ad, wd);
    if (wr) sb[ad] = wd;
    @(negedge clk);
    if (!wr) m_rdata = exp;
    expect_cycle(1'b0, 1'b0, !wr, id, 1'b0, 1'b0, 8'h0, 4'h0);
  endtask

  // Same requester, second request presented right after the first ack.
  task automatic b2b(input logic id,
                     input logic wr0, input logic [7:0] ad0, input logic [3:0] wd0, input logic [3:0] e0,
                     input logic wr1, input logic [7:0] ad1, input logic [3:0] wd1, input logic [3:0] e1);
    @(posedge clk); #1;
    drive(id, 1'b1, wr0, ad0, wd0);
    @(negedge clk);
    expect_cycle(1'b1, id, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 4'h0);
    mlast = id;
    @(posedge clk); #1;
    drive(id, 1'b1, wr1, ad1, wd1);
    @(negedge clk);
    expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, wr0, ad0, wd0);
    if (wr0) sb[ad0] = wd0;
    @(negedge clk);
    if (!wr0) m_rdata = e0;
    expect_cycle(1'b1, id, !wr0, id, 1'b0, 1'b0, 8'h0, 4'h0);
    @(posedge clk); #1;
    drive(id, 1'b0, 1'b0, 8'h0, 4'h0);
    @(negedge clk);
    expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, wr1, ad1, wd1);
    if (wr1) sb[ad1] = wd1;
    @(negedge clk);
    if (!wr1) m_rdata = e1;
    expect_cycle(1'b0, 1'b0, !wr1, id, 1'b0, 1'b0, 8'h0, 4'h0);
  endtask

  initial begin
    logic       w, pw, have_p, id, wr;
    logic [7:0] ad;
    logic [3:0] wd;
    int         bad;

    for (int i = 0; i < 256; i++) sb[i] = 4'h0;
    tbl[0] = '{1'b0, 1'b1, 8'h20, 4'h3, 4'h0};
    tbl[1] = '{1'b1, 1'b1, 8'h21, 4'hC, 4'h0};
    tbl[2] = '{1'b1, 1'b1, 8'h7F, 4'h6, 4'h0};
    tbl[3] = '{1'b0, 1'b1, 8'hFF, 4'h9, 4'h0};
    tbl[4] = '{1'b1, 1'b1, 8'h00, 4'h4, 4'h0};
    tbl[5] = '{1'b0, 1'b0, 8'h20, 4'h0, 4'h3};
    tbl[6] = '{1'b1, 1'b0, 8'h21, 4'h0, 4'hC};
    tbl[7] = '{1'b0, 1'b0, 8'hFF, 4'h0, 4'h9};
    tbl[8] = '{1'b1, 1'b0, 8'h7F, 4'h0, 4'h6};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 4'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    mem_clear = 1'b0;

    // A writes 0x5 to 0x10 then reads it back; acks in N and N+2
    b2b(1'b0, 1'b1, 8'h10, 4'h5, 4'h0, 1'b0, 8'h10, 4'h0, 4'h5);

    for (int i = 0; i < 9; i++) txn(tbl[i].id, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].exp);

    // Simultaneous reads held continuously: A 0x20, B 0x21
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b0, 8'h20, 4'h0);
    drive(1'b1, 1'b1, 1'b0, 8'h21, 4'h0);
    have_p = 1'b0;
    pw = 1'b0;
    w = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        if (have_p) m_rdata = pw ? 4'hC : 4'h3;
        if (k <= 10) begin
          w = ref_winner(1'b1, 1'b1, mlast);
          expect_cycle(1'b1, w, have_p, pw, 1'b0, 1'b0, 8'h0, 4'h0);
          mlast = w;
        end else begin
          expect_cycle(1'b0, 1'b0, have_p, pw, 1'b0, 1'b0, 8'h0, 4'h0);
        end
        have_p = (k <= 10);
        pw = w;
        if (k == 10) begin
          @(posedge clk); #1;
          drive(1'b0, 1'b0, 1'b0, 8'h0, 4'h0);
          drive(1'b1, 1'b0, 1'b0, 8'h0, 4'h0);
        end
      end else begin
        expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, w ? 8'h21 : 8'h20, 4'h0);
      end
    end

    // Reset asserted asynchronously in the middle of B's write of 0xA to 0x7F
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b1, 8'h7F, 4'hA);
    @(negedge clk);
    expect_cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 4'h0);
    mlast = 1'b1;
    @(posedge clk); #3;
    drive(1'b1, 1'b0, 1'b0, 8'h0, 4'h0);
    reset_n = 1'b0;
    #1;
    chk("rst_ram_we", 32'(ram_we), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_bus_ram_only", 32'(ram_data), 32'(mem[ram_addr]));
    m_rdata = 4'h0;
    mlast = 1'b1;
    @(negedge clk);
    expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 4'h0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    expect_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 4'h0);
    chk("no_commit_7f", 32'(mem[8'h7F]), 32'h6);
    txn(1'b1, 1'b0, 8'h7F, 4'h0, 4'h6);

    // Back-to-back B reads at both address extremes
    b2b(1'b1, 1'b0, 8'hFF, 4'h0, 4'h9, 1'b0, 8'h00, 4'h0, 4'h4);

    // Randomised single-requester traffic against the scoreboard
    for (int i = 0; i < 200; i++) begin
      id = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      ad = {4'h3, 4'($urandom_range(0, 15))};
      wd = 4'($urandom_range(0, 15));
      txn(id, wr, ad, wd, sb[ad]);
    end

    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== sb[i]) bad++;
    chk("final_mem_mismatches", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
